wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the MIPS datapath, sitting directly upstream of the register file's write port. It registers the MEM-stage result, aligns and sign/zero-extends load data, and drives the register file's write-enable, write-address and write-data signals. It also merges a second writer, the multicycle mul/div unit, onto the single write port through a one-entry buffer with a starvation guard.

## Interface
- `DATA_W`, 32, datapath width
- `REG_AW`, 5, register address width
- `STARVE_MAX`, 8, maximum cycles a buffered mul/div result may lose arbitration before a pipeline bubble is forced
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `memValid` in 1: MEM-stage instruction present.
- `memReady` out 1: the stage accepts the MEM instruction this cycle.
- `memRegWrite` in 1: the instruction writes a register.
- `memMemToReg` in 1: 1 selects aligned load data; 0 selects the ALU result.
- `memLoadType` in 3: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; other codes are treated as LW.
- `memAddrLo` in 2: low two bits of the load address.
- `memAluResult` in DATA_W: ALU result.
- `memLoadData` in DATA_W: raw data-memory word.
- `memDestReg` in REG_AW: destination register.
- `mdValid` in 1: mul/div result offered.
- `mdReady` out 1: the one-entry buffer is empty.
- `mdDestReg` in REG_AW: mul/div destination register.
- `mdData` in DATA_W: mul/div result.
- `writeEnb` out 1: register-file write enable.
- `writeReg` out REG_AW: register-file write address.
- `writeData` out DATA_W: register-file write data.
- `alignErr` out 1: one-cycle misaligned-load flag; present only with `WB_MISALIGN_TRAP_EN`.

## Operation
- Pipeline write request (`pw`): `memValid && memReady && memRegWrite && memDestReg != 0`. Writes to `$zero` are dropped here; the register file does not guard `$zero`.
- Load alignment is little-endian; the byte lane is selected by `memAddrLo`.
  - LB and LBU select byte `memAddrLo`; LB sign-extends, LBU zero-extends.
  - LH and LHU select half `memAddrLo[1]`; LH sign-extends, LHU zero-extends.
  - LW passes the full word.
- Arbitration is decided each cycle, with the result registered into `writeEnb`, `writeReg` and `writeData`:
  - A `pw` takes the slot.
  - Otherwise, if the buffer is pending, the buffer takes the slot and is cleared.
  - Otherwise `writeEnb` is 0, and `writeReg` and `writeData` hold their values.
- Buffer state machine:
  - **IDLE**: `mdReady`=1. `mdValid` captures `mdDestReg`/`mdData` and moves to PEND. A `mdDestReg`=0 offer is accepted and discarded, staying in IDLE.
  - **PEND**: `mdReady`=0. A free slot drains the buffer and returns to IDLE. Losing the slot to a `pw` increments `starveCnt`; when `starveCnt` reaches `STARVE_MAX`, move to FORCE.
  - **FORCE**: `memReady`=0 for exactly one cycle. The buffer drains, `starveCnt` clears, and the state returns to IDLE.
- `memReady` = (state != FORCE).
- A MEM instruction with `memRegWrite`=0 is consumed and frees the slot in the same cycle.
- Simultaneous drain and new `mdValid`: the offer is not accepted, because `mdReady` is 0 that cycle. It is accepted the following cycle.

## Timing
- MEM instruction accepted at edge N: `writeEnb`/`writeReg`/`writeData` are valid in cycle N+1, and the register file writes at edge N+1. Latency is 1.
- Mul/div accepted at edge N: earliest write outputs in cycle N+1; worst case N+1+`STARVE_MAX`.
- `mdReady` is registered; `memReady` is a decode of the state only, with no combinational path from inputs.
- Reset values:
  - `writeEnb`=0, `writeReg`=0, `writeData`=0.
  - `memReady`=1, `mdReady`=1, `alignErr`=0.
  - state IDLE, `starveCnt`=0.
- Reset mid-operation discards any pending mul/div result and any in-flight write.

## Configuration
- `WB_MISALIGN_TRAP_EN` defined:
  - LW with `memAddrLo`!=0, or LH/LHU with `memAddrLo[0]`=1, suppresses the write (`writeEnb`=0).
  - `alignErr`=1 for the one cycle where the write would have appeared; the slot counts as free for the buffer.
- Not defined: the `alignErr` port is absent. The ignored low bits are truncated: LW uses the full word, and LH/LHU use `memAddrLo[1]` only.

## Structure
- Shared package `mips_pkg`:
  - load-type constants `LD_W`, `LD_H`, `LD_HU`, `LD_B`, `LD_BU`.
  - buffer state encoding `WB_IDLE`, `WB_PEND`, `WB_FORCE`.
  - `REG_ZERO`=5'h0.
- One sub-module: `load_align`. It is purely combinational: inputs `memLoadData`, `memAddrLo`, `memLoadType`; outputs the extended word and a misalign flag.

## Test plan
- **Byte and half loads**: `memLoadData`=0x8899AABB.
  - LB with addrLo=1 → `writeData`=0xFFFFFFAA.
  - LBU with addrLo=1 → 0x000000AA.
  - LH with addrLo=2 → 0xFFFF8899.
  - LHU with addrLo=0 → 0x0000AABB.
  - In each case `writeEnb`=1 exactly one cycle after acceptance.
- **`$zero` suppression**: `memRegWrite`=1, `memDestReg`=0, ALU result 0x1234 → `writeEnb` stays 0.
- **Free-slot drain**: `mdValid` with reg 9, data 0x55 while the pipeline sends `memRegWrite`=0 → `writeReg`=9, `writeData`=0x55 two cycles after the offer; `mdReady` returns to 1.
- **Starvation guard**: buffer pending with back-to-back `pw` to reg 8.
  - After 8 lost cycles, `memReady`=0 for exactly one cycle.
  - The mul/div write appears in that cycle's output.
  - The pipeline resumes with no instruction lost or duplicated.
- **Reset mid-operation**: assert `rst_n`=0 with the buffer in PEND, asynchronously between edges → all outputs reach their reset values immediately; the buffered result is never written after release.
- **Misaligned load with `WB_MISALIGN_TRAP_EN`**: LW with addrLo=2 → `writeEnb`=0 and `alignErr`=1 for one cycle. Without the macro, the same stimulus writes the full word.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: load-type codes, write-back buffer states
// and the hard-wired zero register.
package mips_pkg;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_PEND  = 2'd1,
    WB_FORCE = 2'd2
  } wb_state_e;

  localparam logic [4:0] REG_ZERO = 5'h0;

endpackage

// File: rtl/load_align.sv
// Little-endian load alignment with sign/zero extension; purely combinational.
// Also flags loads whose address is not naturally aligned for their size.
module load_align
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] memLoadData,
  input  logic [1:0]        memAddrLo,
  input  logic [2:0]        memLoadType,
  output logic [DATA_W-1:0] alignedData,
  output logic              misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte      = memLoadData[{memAddrLo, 3'b000} +: 8];
    w_half      = memLoadData[{memAddrLo[1], 4'b0000} +: 16];
    alignedData = memLoadData;
    misalign    = 1'b0;
    case (memLoadType)
      LD_H: begin
        alignedData = {{(DATA_W-16){w_half[15]}}, w_half};
        misalign    = memAddrLo[0];
      end
      LD_HU: begin
        alignedData = {{(DATA_W-16){1'b0}}, w_half};
        misalign    = memAddrLo[0];
      end
      LD_B:    alignedData = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LD_BU:   alignedData = {{(DATA_W-8){1'b0}}, w_byte};
      // LW and every unused code behave as a full-word load
      default: misalign = (memAddrLo != 2'b00);
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: pipeline/mul-div arbitration onto the register-file port.
// Optional misaligned-load trap enabled by defining WB_MISALIGN_TRAP_EN.
module wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memValid,
  output logic              memReady,
  input  logic              memRegWrite,
  input  logic              memMemToReg,
  input  logic [2:0]        memLoadType,
  input  logic [1:0]        memAddrLo,
  input  logic [DATA_W-1:0] memAluResult,
  input  logic [DATA_W-1:0] memLoadData,
  input  logic [REG_AW-1:0] memDestReg,
  input  logic              mdValid,
  output logic              mdReady,
  input  logic [REG_AW-1:0] mdDestReg,
  input  logic [DATA_W-1:0] mdData,
  output logic              writeEnb,
  output logic [REG_AW-1:0] writeReg,
  output logic [DATA_W-1:0] writeData
`ifdef WB_MISALIGN_TRAP_EN
  ,
  output logic              alignErr
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
`ifdef WB_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  wb_state_e           r_state, w_stateNxt;
  logic [CNT_W-1:0]    r_starveCnt, w_starveNxt;
  logic                r_mdReady;
  logic [REG_AW-1:0]   r_bufReg;
  logic [DATA_W-1:0]   r_bufData;
  logic                r_writeEnb;
  logic [REG_AW-1:0]   r_writeReg;
  logic [DATA_W-1:0]   r_writeData;

  logic [DATA_W-1:0]   w_aligned;
  logic [DATA_W-1:0]   w_pipeData;
  logic                w_misalign;
  logic                w_pw, w_misTrap, w_pwEff;
  logic                w_bufPend, w_bufDrain, w_mdCapture;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .memLoadData (memLoadData),
    .memAddrLo   (memAddrLo),
    .memLoadType (memLoadType),
    .alignedData (w_aligned),
    .misalign    (w_misalign)
  );

  assign memReady   = (r_state != WB_FORCE);
  assign mdReady    = r_mdReady;
  assign writeEnb   = r_writeEnb;
  assign writeReg   = r_writeReg;
  assign writeData  = r_writeData;

  // $zero writes are dropped here because the register file does not guard them
  assign w_pw        = memValid && memReady && memRegWrite &&
                       (memDestReg != REG_AW'(REG_ZERO));
  assign w_misTrap   = TRAP_EN && w_pw && memMemToReg && w_misalign;
  assign w_pwEff     = w_pw && !w_misTrap;
  assign w_pipeData  = memMemToReg ? w_aligned : memAluResult;
  assign w_bufPend   = (r_state != WB_IDLE);
  assign w_bufDrain  = w_bufPend && !w_pwEff;
  assign w_mdCapture = r_mdReady && mdValid && (mdDestReg != REG_AW'(REG_ZERO));

  always_comb begin
    w_stateNxt  = r_state;
    w_starveNxt = r_starveCnt;
    case (r_state)
      WB_IDLE: begin
        if (w_mdCapture) w_stateNxt = WB_PEND;
      end
      WB_PEND: begin
        if (w_pwEff) begin
          w_starveNxt = r_starveCnt + 1'b1;
          if (r_starveCnt == CNT_W'(STARVE_MAX - 1)) w_stateNxt = WB_FORCE;
        end else begin
          w_stateNxt  = WB_IDLE;
          w_starveNxt = '0;
        end
      end
      default: begin
        // FORCE: memReady is low, so the buffer is guaranteed to drain now
        w_stateNxt  = WB_IDLE;
        w_starveNxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WB_IDLE;
      r_starveCnt <= '0;
      r_mdReady   <= 1'b1;
      r_writeEnb  <= 1'b0;
      r_writeReg  <= '0;
      r_writeData <= '0;
    end else begin
      r_state     <= w_stateNxt;
      r_starveCnt <= w_starveNxt;
      r_mdReady   <= (w_stateNxt == WB_IDLE);
      r_writeEnb  <= w_pwEff || w_bufDrain;
      if (w_pwEff) begin
        r_writeReg  <= memDestReg;
        r_writeData <= w_pipeData;
      end else if (w_bufDrain) begin
        r_writeReg  <= r_bufReg;
        r_writeData <= r_bufData;
      end
    end
  end

  // Buffer payload is only meaningful while the state says it is pending
  always_ff @(posedge clk) begin
    if (w_mdCapture) begin
      r_bufReg  <= mdDestReg;
      r_bufData <= mdData;
    end
  end

`ifdef WB_MISALIGN_TRAP_EN
  logic r_alignErr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_alignErr <= 1'b0;
    else        r_alignErr <= w_misTrap;
  end
  assign alignErr = r_alignErr;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_wb_stage;

  localparam int SM = 8;
`ifdef WB_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memValid, memRegWrite, memMemToReg;
  logic [2:0]  memLoadType;
  logic [1:0]  memAddrLo;
  logic [31:0] memAluResult, memLoadData;
  logic [4:0]  memDestReg;
  logic        mdValid;
  logic [4:0]  mdDestReg;
  logic [31:0] mdData;
  logic        memReady, mdReady, writeEnb;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
`ifdef WB_MISALIGN_TRAP_EN
  logic        alignErr;
`endif

  wb_stage #(.DATA_W(32), .REG_AW(5), .STARVE_MAX(SM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .memValid     (memValid),
    .memReady     (memReady),
    .memRegWrite  (memRegWrite),
    .memMemToReg  (memMemToReg),
    .memLoadType  (memLoadType),
    .memAddrLo    (memAddrLo),
    .memAluResult (memAluResult),
    .memLoadData  (memLoadData),
    .memDestReg   (memDestReg),
    .mdValid      (mdValid),
    .mdReady      (mdReady),
    .mdDestReg    (mdDestReg),
    .mdData       (mdData),
    .writeEnb     (writeEnb),
    .writeReg     (writeReg),
    .writeData    (writeData)
`ifdef WB_MISALIGN_TRAP_EN
    ,
    .alignErr     (alignErr)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one pending mul/div slot plus a count of lost arbitrations.
  bit          m_bufV;
  logic [4:0]  m_bufReg;
  logic [31:0] m_bufData;
  int          m_lost;
  logic        e_enb, e_err;
  logic [4:0]  e_reg;
  logic [31:0] e_data;

  task automatic model_reset();
    m_bufV = 0; m_bufReg = '0; m_bufData = '0; m_lost = 0;
    e_enb = 0; e_err = 0; e_reg = '0; e_data = '0;
  endtask

  function automatic logic [31:0] align_ref(input logic [2:0] lt, input logic [1:0] a,
                                            input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * (a / 2))) & 32'hFFFF;
    case (lt)
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      default: return d;
    endcase
  endfunction

  function automatic bit misaligned(input logic [2:0] lt, input logic [1:0] a);
    if (lt == 3'd1 || lt == 3'd2) return (a % 2) != 0;
    if (lt == 3'd3 || lt == 3'd4) return 1'b0;
    return a != 0;
  endfunction

  task automatic check_outputs();
    chk("writeEnb", 32'(writeEnb), 32'(e_enb));
    chk("writeReg", 32'(writeReg), 32'(e_reg));
    chk("writeData", writeData, e_data);
    chk("memReady", 32'(memReady), 32'(!(m_bufV && m_lost >= SM)));
    chk("mdReady", 32'(mdReady), 32'(!m_bufV));
`ifdef WB_MISALIGN_TRAP_EN
    chk("alignErr", 32'(alignErr), 32'(e_err));
`endif
  endtask

  // Predict the edge from current inputs, advance one clock, compare.
  task automatic step();
    bit mr, pw, mis, pwe, drain, acc;
    mr    = !(m_bufV && m_lost >= SM);
    pw    = memValid && mr && memRegWrite && (memDestReg != 5'd0);
    mis   = TRAP && pw && memMemToReg && misaligned(memLoadType, memAddrLo);
    pwe   = pw && !mis;
    drain = m_bufV && !pwe;
    acc   = !m_bufV && mdValid && (mdDestReg != 5'd0);
    e_err = mis;
    if (pwe) begin
      e_enb  = 1;
      e_reg  = memDestReg;
      e_data = memMemToReg ? align_ref(memLoadType, memAddrLo, memLoadData) : memAluResult;
    end else if (drain) begin
      e_enb  = 1;
      e_reg  = m_bufReg;
      e_data = m_bufData;
    end else begin
      e_enb = 0;
    end
    if (drain) begin
      m_bufV = 0;
      m_lost = 0;
    end else if (m_bufV) begin
      m_lost++;
    end
    if (acc) begin
      m_bufV = 1; m_bufReg = mdDestReg; m_bufData = mdData; m_lost = 0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    memValid = 0; memRegWrite = 0; memMemToReg = 0; memLoadType = 3'd0;
    memAddrLo = 2'd0; memAluResult = '0; memLoadData = '0; memDestReg = '0;
    mdValid = 0; mdDestReg = '0; mdData = '0;
  endtask

  task automatic set_load(input logic [2:0] lt, input logic [1:0] a, input logic [4:0] rd);
    memValid = 1; memRegWrite = 1; memMemToReg = 1; memLoadType = lt;
    memAddrLo = a; memLoadData = 32'h8899AABB; memAluResult = 32'hDEAD0000; memDestReg = rd;
  endtask

  int lowCnt, lowAt, mdSeen, expSeq, seqNext;
  bit pre;

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    #12;
    chk("rst_writeEnb", 32'(writeEnb), 32'd0);
    chk("rst_writeReg", 32'(writeReg), 32'd0);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_memReady", 32'(memReady), 32'd1);
    chk("rst_mdReady", 32'(mdReady), 32'd1);
    rst_n = 1;

    // Byte and half loads of 0x8899AABB
    set_load(3'd3, 2'd1, 5'd3); step(); chk("lb_a1", writeData, 32'hFFFFFFAA);
    chk("lb_enb", 32'(writeEnb), 32'd1);
    set_load(3'd4, 2'd1, 5'd3); step(); chk("lbu_a1", writeData, 32'h000000AA);
    set_load(3'd1, 2'd2, 5'd3); step(); chk("lh_a2", writeData, 32'hFFFF8899);
    set_load(3'd2, 2'd0, 5'd3); step(); chk("lhu_a0", writeData, 32'h0000AABB);
    idle_inputs(); step(); chk("load_enb_one_cycle", 32'(writeEnb), 32'd0);

    // $zero destination is dropped
    memValid = 1; memRegWrite = 1; memMemToReg = 0; memDestReg = 5'd0; memAluResult = 32'h1234;
    step(); chk("zero_suppress", 32'(writeEnb), 32'd0);

    // Free-slot drain: offer, then a non-writing pipeline instruction
    idle_inputs();
    mdValid = 1; mdDestReg = 5'd9; mdData = 32'h55;
    memValid = 1; memRegWrite = 0;
    step(); chk("drain_pend_mdReady", 32'(mdReady), 32'd0);
    mdValid = 0;
    step();
    chk("drain_enb", 32'(writeEnb), 32'd1);
    chk("drain_reg", 32'(writeReg), 32'd9);
    chk("drain_data", writeData, 32'h55);
    chk("drain_mdReady", 32'(mdReady), 32'd1);

    // Starvation guard: pipeline writes reg 8 every cycle it is allowed to
    idle_inputs();
    memValid = 1; memRegWrite = 1; memDestReg = 5'd8;
    mdValid = 1; mdDestReg = 5'd9; mdData = 32'h77;
    lowCnt = 0; lowAt = -1; mdSeen = 0; expSeq = 100; seqNext = 100;
    for (int i = 0; i < 14; i++) begin
      memAluResult = seqNext;
      pre = memReady;
      step();
      mdValid = 0;
      if (pre) seqNext++;
      if (!memReady) begin
        lowCnt++;
        lowAt = i;
      end
      if (writeEnb && writeReg == 5'd8) begin
        chk("starve_seq", writeData, 32'(expSeq));
        expSeq++;
      end
      if (writeEnb && writeReg == 5'd9) begin
        mdSeen++;
        chk("starve_md_data", writeData, 32'h77);
      end
    end
    chk("starve_bubble_cnt", 32'(lowCnt), 32'd1);
    chk("starve_bubble_at", 32'(lowAt), 32'(SM));
    chk("starve_md_once", 32'(mdSeen), 32'd1);
    chk("starve_no_loss", 32'(expSeq), 32'(seqNext));

    // Asynchronous reset while a mul/div result is pending
    mdValid = 1; mdDestReg = 5'd10; mdData = 32'hAB;
    memAluResult = 32'h999;
    step();
    mdValid = 0;
    step();
    chk("rst_mid_pending", 32'(mdReady), 32'd0);
    #3 rst_n = 0;
    #1;
    chk("rstm_writeEnb", 32'(writeEnb), 32'd0);
    chk("rstm_writeReg", 32'(writeReg), 32'd0);
    chk("rstm_writeData", writeData, 32'd0);
    chk("rstm_memReady", 32'(memReady), 32'd1);
    chk("rstm_mdReady", 32'(mdReady), 32'd1);
    model_reset();
    idle_inputs();
    #2 rst_n = 1;
    mdSeen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (writeEnb) mdSeen++;
    end
    chk("rstm_no_write", 32'(mdSeen), 32'd0);

    // Misaligned LW
    set_load(3'd0, 2'd2, 5'd4);
    step();
`ifdef WB_MISALIGN_TRAP_EN
    chk("mis_enb", 32'(writeEnb), 32'd0);
    chk("mis_err", 32'(alignErr), 32'd1);
    idle_inputs(); step();
    chk("mis_err_clear", 32'(alignErr), 32'd0);
`else
    chk("mis_full_word", writeData, 32'h8899AABB);
    chk("mis_enb", 32'(writeEnb), 32'd1);
    idle_inputs(); step();
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      memValid     = ($urandom_range(0, 9) < 8);
      memRegWrite  = ($urandom_range(0, 3) != 0);
      memMemToReg  = $urandom_range(0, 1);
      memLoadType  = 3'($urandom_range(0, 7));
      memAddrLo    = 2'($urandom_range(0, 3));
      memAluResult = $urandom;
      memLoadData  = $urandom;
      memDestReg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mdValid      = ($urandom_range(0, 9) < 3);
      mdDestReg    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mdData       = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
